reg_rename_file: RTL and testbench

Architectural register file with per-register rename tags: the commit-side consumer of the reorder buffer's retire stream and the operand source for dispatch. Dispatch renames a destination register to a ROB index. Operand reads return either a committed value or the ROB index that will produce it. Commits write values and clear the rename tag only when the committing ROB entry is still the newest producer. Sits between decode/dispatch, the reservation stations and the ROB.

---
 rtl/reg_rename_file_if.sv | 38 +++
 rtl/reg_rename_file.sv | 61 ++++++
 tb/tb_reg_rename_file.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/reg_rename_file_if.sv
// reg_rename_file_if: dispatch/commit/operand bundle for reg_rename_file.
//   rdy, flush            global ready and recovery flush
//   cmt_en/rd/val/tag     retire-side register write from the ROB
//   ren_en/rd/tag         dispatch-side destination rename
//   rsN_idx               operand lookup index
//   rsN_busy/val/tag      operand result: committed value or pending producer
//   master = dispatch/ROB side, slave = register file
interface reg_rename_file_if #(
    parameter int REG_IDX_W = 5,
    parameter int ROB_IDX_W = 4
) ();
    logic                 rdy;
    logic                 flush;
    logic                 cmt_en;
    logic [REG_IDX_W-1:0] cmt_rd;
    logic [31:0]          cmt_val;
    logic [ROB_IDX_W-1:0] cmt_tag;
    logic                 ren_en;
    logic [REG_IDX_W-1:0] ren_rd;
    logic [ROB_IDX_W-1:0] ren_tag;
    logic [REG_IDX_W-1:0] rs1_idx;
    logic [REG_IDX_W-1:0] rs2_idx;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic [31:0]          rs1_val;
    logic [31:0]          rs2_val;
    logic [ROB_IDX_W-1:0] rs1_tag;
    logic [ROB_IDX_W-1:0] rs2_tag;

    modport master (
        output rdy, flush, cmt_en, cmt_rd, cmt_val, cmt_tag, ren_en, ren_rd, ren_tag, rs1_idx, rs2_idx,
        input  rs1_busy, rs2_busy, rs1_val, rs2_val, rs1_tag, rs2_tag
    );
    modport slave (
        input  rdy, flush, cmt_en, cmt_rd, cmt_val, cmt_tag, ren_en, ren_rd, ren_tag, rs1_idx, rs2_idx,
        output rs1_busy, rs2_busy, rs1_val, rs2_val, rs1_tag, rs2_tag
    );
endinterface

// File: rtl/reg_rename_file.sv
// reg_rename_file: architectural register file with per-register ROB rename tags.
//   clk, rst  clock, synchronous active-high reset
//   bus       reg_rename_file_if.slave: commit, rename, flush, rdy and two read ports
// A register is busy while its tag is nonzero; tag 0 means the committed value is current.
module reg_rename_file #(
    parameter int REG_NUM   = 32,
    parameter int REG_IDX_W = 5,
    parameter int ROB_IDX_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_rename_file_if.slave      bus
);
    logic [31:0]          value [REG_NUM];
    logic [ROB_IDX_W-1:0] tag   [REG_NUM];
    logic [REG_IDX_W-1:0] cmt_rd, ren_rd, rs1, rs2;
    logic [ROB_IDX_W-1:0] cmt_tag;
    logic                 cmt_ok, hit1, hit2;

    assign cmt_rd  = bus.cmt_rd;
    assign ren_rd  = bus.ren_rd;
    assign rs1     = bus.rs1_idx;
    assign rs2     = bus.rs2_idx;
    assign cmt_tag = bus.cmt_tag;
    assign cmt_ok  = bus.cmt_en && cmt_rd != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value[i] <= '0;
                tag[i]   <= '0;
            end
        end else if (bus.rdy) begin
            if (cmt_ok) begin
                value[cmt_rd] <= bus.cmt_val;
                if (tag[cmt_rd] == cmt_tag)
                    tag[cmt_rd] <= '0;
            end
            // flush overrides the commit's tag clear and drops any rename
            if (bus.flush) begin
                for (int i = 0; i < REG_NUM; i++)
                    tag[i] <= '0;
            end else if (bus.ren_en && ren_rd != '0) begin
                tag[ren_rd] <= bus.ren_tag;
            end
        end
    end

    // bypass only when the commit retires the newest producer of the register
    assign hit1 = cmt_ok && cmt_rd == rs1 && tag[rs1] == cmt_tag;
    assign hit2 = cmt_ok && cmt_rd == rs2 && tag[rs2] == cmt_tag;

    always_comb begin
        bus.rs1_busy = rs1 != '0 && !hit1 && tag[rs1] != '0;
        bus.rs1_tag  = bus.rs1_busy ? tag[rs1] : '0;
        bus.rs1_val  = hit1 ? bus.cmt_val : (rs1 == '0 ? '0 : value[rs1]);
        bus.rs2_busy = rs2 != '0 && !hit2 && tag[rs2] != '0;
        bus.rs2_tag  = bus.rs2_busy ? tag[rs2] : '0;
        bus.rs2_val  = hit2 ? bus.cmt_val : (rs2 == '0 ? '0 : value[rs2]);
    end
endmodule

// File: tb/tb_reg_rename_file.sv
// tb_reg_rename_file: directed self-checking bench for reg_rename_file.
module tb_reg_rename_file;
    logic clk = 0;
    logic rst = 0;
    int   checks = 0;
    int   failures = 0;
    logic [36:0] obs;

    reg_rename_file_if #(.REG_IDX_W(5), .ROB_IDX_W(4)) bus ();

    reg_rename_file #(.REG_NUM(32), .REG_IDX_W(5), .ROB_IDX_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.rdy = 1; bus.flush = 0;
        bus.cmt_en = 0; bus.cmt_rd = 0; bus.cmt_val = 0; bus.cmt_tag = 0;
        bus.ren_en = 0; bus.ren_rd = 0; bus.ren_tag = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] t);
        bus.cmt_en = 1; bus.cmt_rd = rd; bus.cmt_val = v; bus.cmt_tag = t;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [3:0] t);
        bus.ren_en = 1; bus.ren_rd = rd; bus.ren_tag = t;
    endtask

    task automatic test_reset();
        idle(); bus.rs1_idx = 5; bus.rs2_idx = 0;
        rst = 1; tick(); rst = 0;
        obs = {bus.rs1_busy, bus.rs1_tag, bus.rs1_val}; checks++;
        if (obs !== 37'd0) begin failures++; $display("FAIL reset_x5 got=%h exp=%h", obs, 37'd0); end
        obs = {bus.rs2_busy, bus.rs2_tag, bus.rs2_val}; checks++;
        if (obs !== 37'd0) begin failures++; $display("FAIL reset_x0 got=%h exp=%h", obs, 37'd0); end
    endtask

    task automatic test_x0();
        rename(0, 3); commit(0, 32'hDEADBEEF, 0); bus.rs1_idx = 0; #1;
        obs = {bus.rs1_busy, bus.rs1_tag, bus.rs1_val}; checks++;
        if (obs !== 37'd0) begin failures++; $display("FAIL x0_bypass got=%h exp=%h", obs, 37'd0); end
        tick(); idle(); #1;
        obs = {bus.rs1_busy, bus.rs1_tag, bus.rs1_val}; checks++;
        if (obs !== 37'd0) begin failures++; $display("FAIL x0_stored got=%h exp=%h", obs, 37'd0); end
    endtask

    task automatic test_rename_commit();
        rename(3, 2); bus.rs1_idx = 3; #1;
        obs = {bus.rs1_busy, bus.rs1_tag, bus.rs1_val}; checks++;
        if (obs !== 37'd0) begin failures++; $display("FAIL ren_same_cycle got=%h exp=%h", obs, 37'd0); end
        tick(); idle(); #1;
        obs = {bus.rs1_busy, bus.rs1_tag, bus.rs1_val}; checks++;
        if (obs !== {1'b1, 4'd2, 32'd0}) begin failures++; $display("FAIL ren_x3 got=%h exp=%h", obs, {1'b1, 4'd2, 32'd0}); end
        commit(3, 32'h1234, 2); bus.rs2_idx = 3; #1;
        obs = {bus.rs1_busy, bus.rs1_tag, bus.rs1_val}; checks++;
        if (obs !== {1'b0, 4'd0, 32'h1234}) begin failures++; $display("FAIL cmt_bypass1 got=%h exp=%h", obs, {1'b0, 4'd0, 32'h1234}); end
        obs = {bus.rs2_busy, bus.rs2_tag, bus.rs2_val}; checks++;
        if (obs !== {1'b0, 4'd0, 32'h1234}) begin failures++; $display("FAIL cmt_bypass2 got=%h exp=%h", obs, {1'b0, 4'd0, 32'h1234}); end
        tick(); idle(); #1;
        obs = {bus.rs1_busy, bus.rs1_tag, bus.rs1_val}; checks++;
        if (obs !== {1'b0, 4'd0, 32'h1234}) begin failures++; $display("FAIL cmt_stored got=%h exp=%h", obs, {1'b0, 4'd0, 32'h1234}); end
    endtask

    task automatic test_younger_rename();
        rename(4, 3); tick(); rename(4, 5); tick(); idle();
        commit(4, 7, 3); bus.rs1_idx = 4; #1;
        obs = {bus.rs1_busy, bus.rs1_tag, bus.rs1_val}; checks++;
        if (obs !== {1'b1, 4'd5, 32'd0}) begin failures++; $display("FAIL old_cmt_no_bypass got=%h exp=%h", obs, {1'b1, 4'd5, 32'd0}); end
        tick(); idle(); #1;
        obs = {bus.rs1_busy, bus.rs1_tag, bus.rs1_val}; checks++;
        if (obs !== {1'b1, 4'd5, 32'd7}) begin failures++; $display("FAIL old_cmt_keeps_tag got=%h exp=%h", obs, {1'b1, 4'd5, 32'd7}); end
        commit(4, 9, 5); #1;
        obs = {bus.rs1_busy, bus.rs1_tag, bus.rs1_val}; checks++;
        if (obs !== {1'b0, 4'd0, 32'd9}) begin failures++; $display("FAIL new_cmt_bypass got=%h exp=%h", obs, {1'b0, 4'd0, 32'd9}); end
        tick(); idle(); #1;
        obs = {bus.rs1_busy, bus.rs1_tag, bus.rs1_val}; checks++;
        if (obs !== {1'b0, 4'd0, 32'd9}) begin failures++; $display("FAIL new_cmt_stored got=%h exp=%h", obs, {1'b0, 4'd0, 32'd9}); end
    endtask

    task automatic test_same_cycle();
        rename(6, 1); tick(); idle();
        commit(6, 32'hAA, 1); rename(6, 4); bus.rs1_idx = 6; #1;
        obs = {bus.rs1_busy, bus.rs1_tag, bus.rs1_val}; checks++;
        if (obs !== {1'b0, 4'd0, 32'hAA}) begin failures++; $display("FAIL same_bypass got=%h exp=%h", obs, {1'b0, 4'd0, 32'hAA}); end
        tick(); idle(); #1;
        obs = {bus.rs1_busy, bus.rs1_tag, bus.rs1_val}; checks++;
        if (obs !== {1'b1, 4'd4, 32'hAA}) begin failures++; $display("FAIL rename_wins got=%h exp=%h", obs, {1'b1, 4'd4, 32'hAA}); end
    endtask

    task automatic test_flush();
        for (int i = 1; i < 32; i++) begin
            rename(5'(i), 4'((i % 15) + 1)); tick();
        end
        idle(); bus.rs1_idx = 10; #1;
        obs = {bus.rs1_busy, bus.rs1_tag, bus.rs1_val}; checks++;
        if (obs !== {1'b1, 4'd11, 32'd0}) begin failures++; $display("FAIL pre_flush_x10 got=%h exp=%h", obs, {1'b1, 4'd11, 32'd0}); end
        bus.flush = 1; commit(2, 32'h55, 3); rename(7, 6); tick(); idle();
        for (int i = 0; i < 32; i++) begin
            bus.rs1_idx = 5'(i); #1; checks++;
            if (bus.rs1_busy !== 1'b0 || bus.rs1_tag !== 4'd0) begin
                failures++; $display("FAIL flush_clear x%0d busy=%b tag=%0d exp busy=0 tag=0", i, bus.rs1_busy, bus.rs1_tag);
            end
        end
        bus.rs1_idx = 2; bus.rs2_idx = 6; #1;
        obs = {bus.rs1_busy, bus.rs1_tag, bus.rs1_val}; checks++;
        if (obs !== {1'b0, 4'd0, 32'h55}) begin failures++; $display("FAIL flush_cmt_x2 got=%h exp=%h", obs, {1'b0, 4'd0, 32'h55}); end
        obs = {bus.rs2_busy, bus.rs2_tag, bus.rs2_val}; checks++;
        if (obs !== {1'b0, 4'd0, 32'hAA}) begin failures++; $display("FAIL flush_keep_x6 got=%h exp=%h", obs, {1'b0, 4'd0, 32'hAA}); end
    endtask

    task automatic test_stall();
        rename(8, 7); tick(); idle();
        bus.rdy = 0; bus.flush = 1; commit(8, 32'h77, 7); rename(9, 2);
        bus.rs1_idx = 8; bus.rs2_idx = 9; #1;
        obs = {bus.rs1_busy, bus.rs1_tag, bus.rs1_val}; checks++;
        if (obs !== {1'b0, 4'd0, 32'h77}) begin failures++; $display("FAIL stall_bypass got=%h exp=%h", obs, {1'b0, 4'd0, 32'h77}); end
        tick(); idle(); #1;
        obs = {bus.rs1_busy, bus.rs1_tag, bus.rs1_val}; checks++;
        if (obs !== {1'b1, 4'd7, 32'd0}) begin failures++; $display("FAIL stall_x8 got=%h exp=%h", obs, {1'b1, 4'd7, 32'd0}); end
        obs = {bus.rs2_busy, bus.rs2_tag, bus.rs2_val}; checks++;
        if (obs !== 37'd0) begin failures++; $display("FAIL stall_x9 got=%h exp=%h", obs, 37'd0); end
    endtask

    task automatic test_back_to_back();
        rename(10, 1); tick(); idle();
        rename(11, 2); commit(10, 32'h10, 1); tick(); idle();
        commit(11, 32'h11, 2); commit(11, 32'h11, 2); tick(); idle();
        bus.rs1_idx = 10; bus.rs2_idx = 11; #1;
        obs = {bus.rs1_busy, bus.rs1_tag, bus.rs1_val}; checks++;
        if (obs !== {1'b0, 4'd0, 32'h10}) begin failures++; $display("FAIL b2b_x10 got=%h exp=%h", obs, {1'b0, 4'd0, 32'h10}); end
        obs = {bus.rs2_busy, bus.rs2_tag, bus.rs2_val}; checks++;
        if (obs !== {1'b0, 4'd0, 32'h11}) begin failures++; $display("FAIL b2b_x11 got=%h exp=%h", obs, {1'b0, 4'd0, 32'h11}); end
    endtask

    initial begin
        idle(); bus.rs1_idx = 0; bus.rs2_idx = 0;
        #1;
        test_reset();
        test_x0();
        test_rename_commit();
        test_younger_rename();
        test_same_cycle();
        test_flush();
        test_stall();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
